idma_axi_read_mo: RTL and testbench

- Multi-outstanding AXI4 R-channel read task for the iDMA transport layer.
- Queues up to NumOutstanding read-datapath requests, each describing one AXI burst.
- Consumes R beats in order and masks/rotates byte-valids into the byte-FIFO buffer.
- Emits exactly one datapath response per burst, carrying accumulated worst-case RRESP and a beat-count mismatch flag.
- Sits between the transport-layer AR issuer (AR handled externally) and the realignment buffer.

---
 rtl/idma_axi_read_mo_if.sv | 76 +++++++
 rtl/idma_axi_read_mo.sv | 176 +++++++++++++++++
 tb/tb_idma_axi_read_mo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_axi_read_mo_if.sv
`default_nettype none
// ============================================================================
// Module      : idma_axi_read_mo_if
// Description : Bundle of the handshake and bus signals of idma_axi_read_mo.
//               Signal names follow the design's port view (_i = into the
//               design, _o = out of the design).
//               Ports grouped here:
//                 dp_req_*   : read-datapath request (offset, tailer, shift,
//                              len, valid/ready)
//                 dp_rsp_*   : per-burst response (resp, len_err,
//                              valid/ready)
//                 axi_r_*    : AXI4 R channel (data, resp, last, valid/ready)
//                 buffer_in* : per-byte push into the realignment buffer
//                 pending_o  : request-queue occupancy
//               Modport slave is the design's view. Modport master is the
//               view of whatever drives and observes the design.
// Revision    : 1.0 - initial release
// ============================================================================
interface idma_axi_read_mo_if #(
   parameter int unsigned StrbWidth      = 16,
   parameter int unsigned NumOutstanding = 4
);
   localparam int unsigned OffW = $clog2(StrbWidth);
   localparam int unsigned CntW = $clog2(NumOutstanding + 1);

   logic [OffW-1:0]        dp_req_offset_i;
   logic [OffW-1:0]        dp_req_tailer_i;
   logic [OffW-1:0]        dp_req_shift_i;
   logic [7:0]             dp_req_len_i;
   logic                   dp_req_valid_i;
   logic                   dp_req_ready_o;

   logic [1:0]             dp_rsp_resp_o;
   logic                   dp_rsp_len_err_o;
   logic                   dp_rsp_valid_o;
   logic                   dp_rsp_ready_i;

   logic [8*StrbWidth-1:0] axi_r_data_i;
   logic [1:0]             axi_r_resp_i;
   logic                   axi_r_last_i;
   logic                   axi_r_valid_i;
   logic                   axi_r_ready_o;

   logic [8*StrbWidth-1:0] buffer_in_o;
   logic [StrbWidth-1:0]   buffer_in_valid_o;
   logic [StrbWidth-1:0]   buffer_in_ready_i;

   logic [CntW-1:0]        pending_o;

   modport slave (
      input  dp_req_offset_i, dp_req_tailer_i, dp_req_shift_i, dp_req_len_i,
      input  dp_req_valid_i,
      output dp_req_ready_o,
      output dp_rsp_resp_o, dp_rsp_len_err_o, dp_rsp_valid_o,
      input  dp_rsp_ready_i,
      input  axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_valid_i,
      output axi_r_ready_o,
      output buffer_in_o, buffer_in_valid_o,
      input  buffer_in_ready_i,
      output pending_o
   );

   modport master (
      output dp_req_offset_i, dp_req_tailer_i, dp_req_shift_i, dp_req_len_i,
      output dp_req_valid_i,
      input  dp_req_ready_o,
      input  dp_rsp_resp_o, dp_rsp_len_err_o, dp_rsp_valid_o,
      output dp_rsp_ready_i,
      output axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_valid_i,
      input  axi_r_ready_o,
      input  buffer_in_o, buffer_in_valid_o,
      output buffer_in_ready_i,
      input  pending_o
   );
endinterface
`default_nettype wire

// File: rtl/idma_axi_read_mo.sv
`default_nettype none
// ============================================================================
// Module      : idma_axi_read_mo
// Description : Multi-outstanding AXI4 R-channel read task for the iDMA
//               transport layer. Up to NumOutstanding burst descriptors are
//               queued. R beats are consumed in order. Each beat's byte
//               valids are masked (first-beat offset, last-beat tailer) and
//               rotated by the realignment shift before being pushed into
//               the byte buffer. Exactly one response is produced per
//               burst, together with its last beat. It carries the worst
//               RRESP seen and a flag for an RLAST/len mismatch.
// Ports       : clk_i, rst_i (async, active high), bus (slave modport:
//               dp_req_*, dp_rsp_*, axi_r_*, buffer_in_*, pending_o)
// Revision    : 1.0 - initial release
// ============================================================================
module idma_axi_read_mo #(
   parameter int unsigned StrbWidth      = 16,
   parameter int unsigned NumOutstanding = 4,
   parameter int unsigned OffW           = $clog2(StrbWidth),
   parameter int unsigned CntW           = $clog2(NumOutstanding + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   idma_axi_read_mo_if.slave  bus
);
   localparam int unsigned     PtrW       = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
   localparam logic [PtrW-1:0] c_last_ptr = PtrW'(NumOutstanding - 1);
   localparam logic [CntW-1:0] c_depth    = CntW'(NumOutstanding);
   localparam logic [OffW:0]   c_strb     = (OffW + 1)'(StrbWidth);

   typedef struct packed {
      logic [OffW-1:0] offset;
      logic [OffW-1:0] tailer;
      logic [OffW-1:0] shift;
      logic [7:0]      len;
   } req_t;

   // Request queue storage and pointers
   req_t            mem_q [NumOutstanding];
   req_t            mem_d [NumOutstanding];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] occ_q, occ_d;

   // Per-burst progress of the head entry
   logic [7:0]      cnt_q, cnt_d;
   logic [1:0]      acc_q, acc_d;
   logic            overrun_q, overrun_d;

   req_t                   head;
   logic                   full, head_valid, push, pop, first;
   logic                   in_ready, r_ready, beat_acc;
   logic [StrbWidth-1:0]   mask, mask_in;
   logic [2*StrbWidth-1:0] mask_rot;
   logic [OffW:0]          tail_shamt;
   logic [1:0]             resp_max;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == c_last_ptr) ? '0 : p + PtrW'(1);
   endfunction

   assign full       = (occ_q == c_depth);
   assign head_valid = (occ_q != '0);
   assign head       = mem_q[rd_ptr_q];
   assign first      = (cnt_q == 8'd0);

   // A push while full is refused, even if the head pops this cycle.
   assign push = bus.dp_req_valid_i & ~full;

   // Byte mask in read-data space, then rotated into buffer space.
   assign tail_shamt = c_strb - {1'b0, head.tailer};

   always_comb begin
      mask = '1;
      if (first) begin
         mask &= ({StrbWidth{1'b1}} << head.offset);
      end
      if (bus.axi_r_last_i && (head.tailer != '0)) begin
         mask &= ({StrbWidth{1'b1}} >> tail_shamt);
      end
      mask_rot = {mask, mask} >> head.shift;
      mask_in  = mask_rot[StrbWidth-1:0];
   end

   // Only buffer lanes that will receive a byte need to be ready.
   assign in_ready = &(bus.buffer_in_ready_i | ~mask_in);

   // The last beat also waits for the response channel, since the response
   // handshake is the last-beat handshake.
   assign r_ready  = head_valid & in_ready & (~bus.axi_r_last_i | bus.dp_rsp_ready_i);
   assign beat_acc = bus.axi_r_valid_i & r_ready;
   assign pop      = beat_acc & bus.axi_r_last_i;

   assign resp_max = (bus.axi_r_resp_i > acc_q) ? bus.axi_r_resp_i : acc_q;

   assign bus.dp_req_ready_o    = ~full & ~rst_i;
   assign bus.axi_r_ready_o     = r_ready;
   assign bus.buffer_in_o       = bus.axi_r_data_i;
   assign bus.buffer_in_valid_o = beat_acc ? mask_in : '0;
   assign bus.dp_rsp_valid_o    = bus.axi_r_valid_i & bus.axi_r_last_i & head_valid & in_ready;
   assign bus.dp_rsp_resp_o     = resp_max;
   assign bus.dp_rsp_len_err_o  = overrun_q | (cnt_q != head.len);
   assign bus.pending_o         = occ_q;

   // Queue storage write
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{offset: bus.dp_req_offset_i,
                             tailer: bus.dp_req_tailer_i,
                             shift:  bus.dp_req_shift_i,
                             len:    bus.dp_req_len_i};
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Pointers, occupancy and burst progress
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      overrun_d = overrun_q;

      if (push) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
         occ_d = occ_q + CntW'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - CntW'(1);
      end

      if (beat_acc) begin
         if (bus.axi_r_last_i) begin
            cnt_d     = 8'd0;
            acc_d     = 2'd0;
            overrun_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 8'd1;
            acc_d = resp_max;
            // A non-last beat at index len means RLAST is overdue. The
            // counter alone cannot show this once it moves past len.
            if (cnt_q == head.len) begin
               overrun_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         cnt_q     <= 8'd0;
         acc_q     <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         overrun_q <= overrun_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_idma_axi_read_mo.sv
`default_nettype none
// ============================================================================
// Module      : tb_idma_axi_read_mo
// Description : Randomized scoreboard bench for idma_axi_read_mo. For each
//               burst issued, the expected buffer masks, data and response
//               are queued. A monitor compares them whenever the design
//               accepts a beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idma_axi_read_mo;
   localparam int S = 16;
   localparam int N = 4;

   typedef struct packed {
      logic [8*S-1:0] data;
      logic [1:0]     resp;
      logic           last;
      logic [S-1:0]   mask;
   } beat_t;

   typedef struct packed {
      logic [1:0] resp;
      logic       len_err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   idma_axi_read_mo_if #(.StrbWidth(S), .NumOutstanding(N)) bus ();

   idma_axi_read_mo #(.StrbWidth(S), .NumOutstanding(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   beat_t drv_q[$];
   beat_t exp_q[$];
   rsp_t  exp_rsp[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    mdl_cnt = 0;

   task automatic chk(input string nm, input logic [8*S-1:0] act, input logic [8*S-1:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Reference model: the byte-level meaning of a burst. Byte b of beat i is
   // delivered if it lies past the offset (first beat) and within the
   // tailer (last beat). It lands in buffer lane (b - shift) mod S. The
   // response carries the maximum RRESP and flags any beat count other
   // than len+1. Call at posedge+1; returns at posedge+1 after acceptance.
   task automatic send_req(input int off, input int tail, input int sh, input int len, input int nbeats);
      logic [1:0] worst;
      int t;
      worst = 2'd0;
      for (int i = 0; i < nbeats; i++) begin
         beat_t b;
         b.data = {$urandom, $urandom, $urandom, $urandom};
         b.resp = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
         b.last = (i == nbeats - 1);
         b.mask = '0;
         for (int byt = 0; byt < S; byt++) begin
            bit keep;
            keep = 1'b1;
            if (i == 0 && byt < off) keep = 1'b0;
            if (b.last && tail != 0 && byt >= tail) keep = 1'b0;
            if (keep) b.mask[(byt - sh + S) % S] = 1'b1;
         end
         if (b.resp > worst) worst = b.resp;
         drv_q.push_back(b);
         exp_q.push_back(b);
      end
      exp_rsp.push_back('{resp: worst, len_err: (nbeats - 1 != len)});

      bus.dp_req_offset_i = 4'(off);
      bus.dp_req_tailer_i = 4'(tail);
      bus.dp_req_shift_i  = 4'(sh);
      bus.dp_req_len_i    = 8'(len);
      bus.dp_req_valid_i  = 1'b1;
      t = 0;
      while (t < 5000) begin
         @(negedge clk);
         if (bus.dp_req_ready_o) break;
         t++;
      end
      if (t >= 5000) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_accept_timeout: ready=%0b, expected 1", bus.dp_req_ready_o);
      end
      @(posedge clk);
      #1;
      bus.dp_req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || exp_rsp.size() != 0) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // R-channel driver with random gaps and random downstream readiness.
   beat_t cur;
   bit    busy = 1'b0;
   bit    took = 1'b0;

   initial begin
      bus.axi_r_valid_i     = 1'b0;
      bus.axi_r_data_i      = '0;
      bus.axi_r_resp_i      = 2'd0;
      bus.axi_r_last_i      = 1'b0;
      bus.buffer_in_ready_i = '1;
      bus.dp_rsp_ready_i    = 1'b1;
      forever begin
         @(negedge clk);
         took = bus.axi_r_valid_i && bus.axi_r_ready_o && !rst;
         @(posedge clk);
         #1;
         if (rst || took) busy = 1'b0;
         bus.buffer_in_ready_i = ($urandom_range(0, 3) == 0) ? S'($urandom) : '1;
         bus.dp_rsp_ready_i    = ($urandom_range(0, 3) != 0);
         if (!busy && !rst && drv_q.size() > 0 && $urandom_range(0, 4) != 0) begin
            cur  = drv_q.pop_front();
            busy = 1'b1;
         end
         bus.axi_r_valid_i = busy;
         bus.axi_r_data_i  = busy ? cur.data : '0;
         bus.axi_r_resp_i  = busy ? cur.resp : 2'd0;
         bus.axi_r_last_i  = busy ? cur.last : 1'b0;
      end
   end

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_pending", bus.pending_o, 0);
            chk("rst_req_ready", bus.dp_req_ready_o, 0);
            chk("rst_r_ready", bus.axi_r_ready_o, 0);
            chk("rst_rsp_valid", bus.dp_rsp_valid_o, 0);
            chk("rst_buf_valid", bus.buffer_in_valid_o, 0);
            mdl_cnt = 0;
         end else begin
            bit push, pop, in_rdy, er;
            beat_t b;
            rsp_t r;
            pop = 1'b0;
            push = bus.dp_req_valid_i && (mdl_cnt < N);
            chk("pending", bus.pending_o, mdl_cnt);
            chk("req_ready", bus.dp_req_ready_o, (mdl_cnt < N));
            if (bus.axi_r_valid_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: beat on bus, expected none");
               end else begin
                  b = exp_q[0];
                  in_rdy = &(bus.buffer_in_ready_i | ~b.mask);
                  er = (mdl_cnt > 0) && in_rdy && (!b.last || bus.dp_rsp_ready_i);
                  chk("r_ready", bus.axi_r_ready_o, er);
                  chk("rsp_valid", bus.dp_rsp_valid_o, b.last && (mdl_cnt > 0) && in_rdy);
                  if (er) begin
                     chk("buf_valid", bus.buffer_in_valid_o, b.mask);
                     chk("buf_data", bus.buffer_in_o, b.data);
                     void'(exp_q.pop_front());
                     if (b.last) begin
                        r = exp_rsp.pop_front();
                        chk("rsp_resp", bus.dp_rsp_resp_o, r.resp);
                        chk("rsp_len_err", bus.dp_rsp_len_err_o, r.len_err);
                        pop = 1'b1;
                     end
                  end else begin
                     chk("buf_valid_stall", bus.buffer_in_valid_o, 0);
                  end
               end
            end else begin
               chk("buf_valid_idle", bus.buffer_in_valid_o, 0);
               chk("rsp_valid_idle", bus.dp_rsp_valid_o, 0);
            end
            mdl_cnt = mdl_cnt + int'(push) - int'(pop);
         end
      end
   end

   // Main sequence
   initial begin
      int t;
      bus.dp_req_valid_i  = 1'b0;
      bus.dp_req_offset_i = '0;
      bus.dp_req_tailer_i = '0;
      bus.dp_req_shift_i  = '0;
      bus.dp_req_len_i    = '0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed bursts: aligned, unaligned 25B, short and long RLAST.
      send_req(0, 0, 0, 3, 4);
      send_req(4, 13, 4, 1, 2);
      send_req(0, 0, 0, 2, 3);
      send_req(0, 0, 0, 3, 3);
      send_req(0, 0, 0, 0, 3);
      send_req(15, 1, 15, 0, 1);
      drain();

      // Random bursts, issued back-to-back so the queue fills up.
      for (int k = 0; k < 60; k++) begin
         int len, nb, sel;
         len = $urandom_range(0, 5);
         sel = $urandom_range(0, 7);
         if (sel == 0) nb = len + 2;
         else if (sel == 1 && len > 0) nb = len;
         else nb = len + 1;
         send_req($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), len, nb);
      end
      drain();

      // Reset in the middle of a burst with two entries queued.
      send_req(3, 0, 2, 3, 4);
      send_req(0, 0, 0, 1, 2);
      t = 0;
      while (exp_q.size() > 5 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      exp_q.delete();
      exp_rsp.delete();
      drv_q.delete();
      bus.dp_req_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // After reset, the first beat of a new burst again gets the offset mask.
      send_req(5, 3, 7, 2, 3);
      for (int k = 0; k < 8; k++) begin
         int len;
         len = $urandom_range(0, 3);
         send_req($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), len, len + 1);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
